sha256_msg_padder: RTL and testbench

//  Upstream feeder for the SHA-256 compression core. Accepts a message as a stream of
//  32-bit big-endian words, applies FIPS 180-4 padding (0x80, zero fill, 64-bit bit length),
//  and emits 512-bit blocks on a valid/accept handshake matching the core's message input.

---
 rtl/sha256_msg_padder_if.sv | 28 ++
 rtl/sha256_msg_padder.sv | 181 ++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_padder_if.sv
// Message-word input stream and 512-bit block output for the SHA-256 padder.
interface sha256_msg_padder_if;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 512;

    logic [WORD_W-1:0] in_data_i;
    logic [2:0]        in_bytes_i;
    logic              in_last_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [BLK_W-1:0]  blk_o;
    logic              blk_first_o;
    logic              blk_last_o;
    logic              blk_valid_o;
    logic              blk_accept_i;

    // Padder side: consumes words, produces blocks.
    modport slave (
        input  in_data_i, in_bytes_i, in_last_i, in_valid_i, blk_accept_i,
        output in_ready_o, blk_o, blk_first_o, blk_last_o, blk_valid_o
    );

    // Feeder/core side: produces words, consumes blocks.
    modport master (
        output in_data_i, in_bytes_i, in_last_i, in_valid_i, blk_accept_i,
        input  in_ready_o, blk_o, blk_first_o, blk_last_o, blk_valid_o
    );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit big-endian words into 512-bit blocks,
// appends 0x80, zero fill and the 64-bit bit length, flags first/last blocks.
module sha256_msg_padder #(
    parameter int unsigned LEN_WIDTH = 64
) (
    input  logic                 sha256_clock_i,
    input  logic                 sha256_reset_i,
    sha256_msg_padder_if.slave   bus
);
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned N_WORDS = 16;
    localparam int unsigned IDX_W   = 5;
    localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

    typedef enum logic [1:0] {S_FILL, S_SEND, S_PAD_BLK, S_SEND_FINAL} state_t;

    state_t                         r_state, w_state;
    logic [N_WORDS-1:0][WORD_W-1:0] r_buf, w_buf;
    logic [IDX_W-1:0]               r_idx, w_idx;
    logic [LEN_WIDTH-1:0]           r_len, w_len;
    logic                           r_first_pend, w_first_pend;
    logic                           r_pad_pend, w_pad_pend;
    logic                           r_pad_w0, w_pad_w0;
    logic                           r_in_ready, w_in_ready;
    logic                           r_blk_valid, w_blk_valid;
    logic                           r_blk_first, w_blk_first;
    logic                           r_blk_last, w_blk_last;

    logic                           w_xfer, w_acc, w_full;
    logic [2:0]                     w_b;
    logic [IDX_W-1:0]               w_pad_idx;
    logic [WORD_W-1:0]              w_last_word;
    logic [LEN_WIDTH-1:0]           w_len_word, w_len_last;
    logic [63:0]                    w_len_ext, w_len_pad;

    // Handshakes and final-word formatting (byte counts above 4 saturate to 4).
    assign w_xfer      = bus.in_valid_i & r_in_ready;
    assign w_acc       = r_blk_valid & bus.blk_accept_i;
    assign w_b         = (bus.in_bytes_i > 3'd4) ? 3'd4 : bus.in_bytes_i;
    assign w_full      = (w_b == 3'd4);
    assign w_pad_idx   = w_full ? (r_idx + IDX_W'(1)) : r_idx;
    assign w_last_word = w_full ? bus.in_data_i
                       : ((bus.in_data_i & ~(32'hFFFF_FFFF >> {w_b, 3'b000}))
                          | (PAD_WORD >> {w_b, 3'b000}));
    assign w_len_word  = r_len + LEN_WIDTH'(32);
    assign w_len_last  = r_len + LEN_WIDTH'({w_b, 3'b000});
    assign w_len_ext   = 64'(w_len_last);
    assign w_len_pad   = 64'(r_len);

    // Next-state and next-output computation.
    always_comb begin
        w_state      = r_state;
        w_buf        = r_buf;
        w_idx        = r_idx;
        w_len        = r_len;
        w_first_pend = r_first_pend;
        w_pad_pend   = r_pad_pend;
        w_pad_w0     = r_pad_w0;
        w_in_ready   = r_in_ready;
        w_blk_valid  = r_blk_valid;
        w_blk_first  = r_blk_first;
        w_blk_last   = r_blk_last;
        unique case (r_state)
            S_FILL: begin
                if (w_xfer && !bus.in_last_i) begin
                    w_buf[r_idx[3:0]] = bus.in_data_i;
                    w_idx             = r_idx + IDX_W'(1);
                    w_len             = w_len_word;
                    if (r_idx == IDX_W'(N_WORDS - 1)) begin
                        w_state     = S_SEND;
                        w_pad_pend  = 1'b0;
                        w_in_ready  = 1'b0;
                        w_blk_valid = 1'b1;
                        w_blk_first = r_first_pend;
                        w_blk_last  = 1'b0;
                    end
                end else if (w_xfer) begin
                    w_len = w_len_last;
                    for (int unsigned t = 0; t < N_WORDS; t++) begin
                        if (IDX_W'(t) == r_idx) begin
                            w_buf[4'(t)] = w_last_word;
                        end else if (IDX_W'(t) > r_idx) begin
                            w_buf[4'(t)] = (w_full && (IDX_W'(t) == r_idx + IDX_W'(1)))
                                         ? PAD_WORD : '0;
                        end
                    end
                    w_in_ready  = 1'b0;
                    w_blk_valid = 1'b1;
                    w_blk_first = r_first_pend;
                    if (w_pad_idx <= IDX_W'(13)) begin
                        w_buf[4'd14] = w_len_ext[63:32];
                        w_buf[4'd15] = w_len_ext[31:0];
                        w_state      = S_SEND_FINAL;
                        w_blk_last   = 1'b1;
                        w_pad_pend   = 1'b0;
                    end else begin
                        // No room for the length: it goes into a trailing pad block.
                        w_state    = S_SEND;
                        w_blk_last = 1'b0;
                        w_pad_pend = 1'b1;
                        w_pad_w0   = (w_pad_idx == IDX_W'(N_WORDS));
                    end
                end
            end
            S_SEND: begin
                if (w_acc) begin
                    w_blk_valid  = 1'b0;
                    w_blk_first  = 1'b0;
                    w_blk_last   = 1'b0;
                    w_first_pend = 1'b0;
                    w_idx        = '0;
                    if (r_pad_pend) begin
                        w_state = S_PAD_BLK;
                    end else begin
                        w_state    = S_FILL;
                        w_in_ready = 1'b1;
                    end
                end
            end
            S_PAD_BLK: begin
                w_buf        = '0;
                w_buf[4'd0]  = r_pad_w0 ? PAD_WORD : '0;
                w_buf[4'd14] = w_len_pad[63:32];
                w_buf[4'd15] = w_len_pad[31:0];
                w_state      = S_SEND_FINAL;
                w_pad_pend   = 1'b0;
                w_blk_valid  = 1'b1;
                w_blk_first  = r_first_pend;
                w_blk_last   = 1'b1;
            end
            S_SEND_FINAL: begin
                if (w_acc) begin
                    w_state      = S_FILL;
                    w_idx        = '0;
                    w_len        = '0;
                    w_first_pend = 1'b1;
                    w_in_ready   = 1'b1;
                    w_blk_valid  = 1'b0;
                    w_blk_first  = 1'b0;
                    w_blk_last   = 1'b0;
                end
            end
            default: w_state = S_FILL;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sha256_clock_i) begin
        if (sha256_reset_i) begin
            r_state      <= S_FILL;
            r_buf        <= '0;
            r_idx        <= '0;
            r_len        <= '0;
            r_first_pend <= 1'b1;
            r_pad_pend   <= 1'b0;
            r_pad_w0     <= 1'b0;
            r_in_ready   <= 1'b1;
            r_blk_valid  <= 1'b0;
            r_blk_first  <= 1'b0;
            r_blk_last   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_buf        <= w_buf;
            r_idx        <= w_idx;
            r_len        <= w_len;
            r_first_pend <= w_first_pend;
            r_pad_pend   <= w_pad_pend;
            r_pad_w0     <= w_pad_w0;
            r_in_ready   <= w_in_ready;
            r_blk_valid  <= w_blk_valid;
            r_blk_first  <= w_blk_first;
            r_blk_last   <= w_blk_last;
        end
    end

    assign bus.in_ready_o  = r_in_ready;
    assign bus.blk_o       = r_buf;
    assign bus.blk_first_o = r_blk_first;
    assign bus.blk_last_o  = r_blk_last;
    assign bus.blk_valid_o = r_blk_valid;
endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: byte-level FIPS 180-4 padding model, block scoreboard.
module tb_sha256_msg_padder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha256_msg_padder_if bus ();

    sha256_msg_padder #(.LEN_WIDTH(64)) dut (
        .sha256_clock_i (clk),
        .sha256_reset_i (rst),
        .bus            (bus)
    );

    typedef struct {
        logic [511:0] blk;
        logic         first;
        logic         last;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] tx_words[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_stall  = 0;
    int          hold_req_cnt = 0;

    logic [511:0] prev_blk;
    logic         prev_first, prev_last, prev_hold;
    exp_t         mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_blk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout_abort(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected progress", name);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    endtask

    // Reference: pad the byte string per FIPS 180-4 and cut it into 64-byte blocks.
    function automatic void model_msg(input int lb);
        byte unsigned bq[$];
        logic [31:0]  w;
        logic [63:0]  nbits;
        exp_t         e;
        int           n, nb, nblk, base;
        n = tx_words.size();
        for (int i = 0; i < n; i++) begin
            w  = tx_words[i];
            nb = (i == n - 1) ? ((lb > 4) ? 4 : lb) : 4;
            for (int k = 0; k < nb; k++) bq.push_back(w[31 - 8 * k -: 8]);
        end
        nbits = 64'(bq.size()) * 64'd8;
        bq.push_back(8'h80);
        while ((bq.size() % 64) != 56) bq.push_back(8'h00);
        for (int k = 7; k >= 0; k--) bq.push_back(nbits[8 * k +: 8]);
        nblk = bq.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.blk = '0;
            for (int t = 0; t < 16; t++) begin
                base = 64 * b + 4 * t;
                e.blk[32 * t +: 32] = {bq[base], bq[base + 1], bq[base + 2], bq[base + 3]};
            end
            e.first = (b == 0);
            e.last  = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic fill_words(input int n, input logic [31:0] seed);
        tx_words.delete();
        for (int i = 0; i < n; i++) tx_words.push_back(seed + 32'(i) * 32'h0103_0507);
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
        int   waited;
        logic took;
        waited = 0;
        took   = 1'b0;
        bus.in_data_i  = d;
        bus.in_bytes_i = nb;
        bus.in_last_i  = last;
        bus.in_valid_i = 1'b1;
        while (!took) begin
            @(negedge clk);
            took = bus.in_ready_o;
            @(posedge clk);
            #1;
            waited++;
            if (waited > 300) timeout_abort("in_ready_wait");
        end
        bus.in_valid_i = 1'b0;
        bus.in_last_i  = 1'b0;
    endtask

    task automatic send_tx(input int lb);
        int n;
        n = tx_words.size();
        model_msg(lb);
        for (int i = 0; i < n; i++)
            send_word(tx_words[i], (i == n - 1) ? 3'(lb) : 3'd0, (i == n - 1));
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            c++;
            if (c > 1000) timeout_abort("block_drain");
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(bus.in_ready_o), 32'd1);
        chk({tag, "_blk_valid"}, 32'(bus.blk_valid_o), 32'd0);
        chk({tag, "_blk_first"}, 32'(bus.blk_first_o), 32'd0);
        chk({tag, "_blk_last"}, 32'(bus.blk_last_o), 32'd0);
        chk_blk({tag, "_blk"}, bus.blk_o, 512'd0);
        @(posedge clk);
        #1;
    endtask

    // Core-side acceptor: mostly accepting, with requested 10-cycle stalls.
    initial begin : acceptor
        int hold_left;
        int hold_seen;
        hold_left = 0;
        hold_seen = 0;
        bus.blk_accept_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_req_cnt != hold_seen) begin
                hold_seen = hold_req_cnt;
                hold_left = 10;
            end
            if (hold_left > 0) begin
                bus.blk_accept_i = 1'b0;
                if (bus.blk_valid_o) hold_left--;
            end else begin
                bus.blk_accept_i = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Output checker: stability while stalled, no input acceptance while a block is
    // pending, and every accepted block against the model queue.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.blk_valid_o), 32'd1);
                chk_blk("hold_blk", bus.blk_o, prev_blk);
                chk("hold_first", 32'(bus.blk_first_o), 32'(prev_first));
                chk("hold_last", 32'(bus.blk_last_o), 32'(prev_last));
            end
            if (bus.blk_valid_o) begin
                chk("ready_while_valid", 32'(bus.in_ready_o), 32'd0);
                if (bus.blk_accept_i) begin
                    prev_hold = 1'b0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_block: got %h expected none", bus.blk_o);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk_blk("blk", bus.blk_o, mon_e.blk);
                        chk("blk_first", 32'(bus.blk_first_o), 32'(mon_e.first));
                        chk("blk_last", 32'(bus.blk_last_o), 32'(mon_e.last));
                    end
                end else begin
                    n_stall++;
                    prev_hold  = 1'b1;
                    prev_blk   = bus.blk_o;
                    prev_first = bus.blk_first_o;
                    prev_last  = bus.blk_last_o;
                end
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin : main
        logic [511:0] lit;
        bus.in_valid_i = 1'b0;
        bus.in_data_i  = '0;
        bus.in_bytes_i = '0;
        bus.in_last_i  = 1'b0;
        rst = 1'b1;

        // Hand-computed pins on the model itself.
        tx_words.delete();
        tx_words.push_back(32'h6162_6300);
        model_msg(3);
        lit = '0;
        lit[31:0]    = 32'h6162_6380;
        lit[511:480] = 32'h0000_0018;
        chk("pin_abc_nblk", 32'(exp_q.size()), 32'd1);
        chk_blk("pin_abc_blk", exp_q[0].blk, lit);
        chk("pin_abc_flags", 32'({exp_q[0].first, exp_q[0].last}), 32'd3);
        exp_q.delete();

        tx_words.delete();
        tx_words.push_back(32'h0000_0000);
        model_msg(0);
        lit = '0;
        lit[31:0] = 32'h8000_0000;
        chk_blk("pin_empty_blk", exp_q[0].blk, lit);
        exp_q.delete();

        fill_words(14, 32'h1111_0000);
        model_msg(4);
        lit = '0;
        lit[511:480] = 32'h0000_01C0;
        chk("pin_14w_nblk", 32'(exp_q.size()), 32'd2);
        chk("pin_14w_w14", exp_q[0].blk[479:448], 32'h8000_0000);
        chk_blk("pin_14w_blk2", exp_q[1].blk, lit);
        exp_q.delete();

        fill_words(16, 32'h2222_0000);
        model_msg(4);
        lit = '0;
        lit[31:0]    = 32'h8000_0000;
        lit[511:480] = 32'h0000_0200;
        chk_blk("pin_16w_blk2", exp_q[1].blk, lit);
        chk("pin_16w_flags2", 32'({exp_q[1].first, exp_q[1].last}), 32'd1);
        exp_q.delete();

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("reset");

        // "abc", empty (with junk data to be masked), 14 and 16 full words.
        tx_words.delete();
        tx_words.push_back(32'h6162_6300);
        send_tx(3);
        wait_drain();
        tx_words.delete();
        tx_words.push_back(32'hDEAD_BEEF);
        send_tx(0);
        wait_drain();
        fill_words(14, 32'h3000_0001);
        send_tx(4);
        fill_words(16, 32'h4000_0002);
        send_tx(4);
        wait_drain();

        // Pad-position boundaries and byte-count saturation, back to back.
        fill_words(15, 32'h5000_0003);
        send_tx(4);
        fill_words(15, 32'h6000_0004);
        send_tx(2);
        fill_words(13, 32'h7000_0005);
        send_tx(4);
        fill_words(14, 32'h7100_0006);
        send_tx(1);
        fill_words(2, 32'hAABB_CCDD);
        send_tx(7);
        fill_words(17, 32'h8000_0006);
        send_tx(1);
        wait_drain();

        // Long stall on the first block while the next message queues behind it.
        hold_req_cnt++;
        fill_words(16, 32'h9000_0007);
        send_tx(3);
        fill_words(5, 32'hA000_0008);
        send_tx(4);
        wait_drain();
        chk("stall_cycles_seen", 32'(n_stall >= 10), 32'd1);

        // Reset in the middle of a message discards it.
        fill_words(7, 32'hB000_0009);
        for (int i = 0; i < 7; i++) send_word(tx_words[i], 3'd0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_reset_vals("midreset");
        tx_words.delete();
        tx_words.push_back(32'h6162_6300);
        send_tx(3);
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
